// File: rtl/alu_pkg.sv
// Shared definitions for the registered ALU: function codes and the flag bundle.
package alu_pkg;

    typedef enum logic [2:0] {
        ALU_ADD = 3'b000,
        ALU_SUB = 3'b001,
        ALU_NOT = 3'b010,
        ALU_AND = 3'b011,
        ALU_OR  = 3'b100,
        ALU_XOR = 3'b101,
        ALU_LT  = 3'b110,
        ALU_EQ  = 3'b111
    } alu_fn_e;

    typedef struct packed {
        logic zero;
        logic overflow;
        logic carry;
    } alu_flags_t;

endpackage

// File: rtl/alu_core.sv
// Combinational ALU datapath: (fn, a, b) -> (res, flags).
// Define ALU_SAT_EN to saturate add/sub results on signed overflow.
module alu_core
    import alu_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  alu_fn_e            fn,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic [WIDTH-1:0]   res,
    output alu_flags_t         flags
);

    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   diff;
    logic             add_ovf;
    logic             sub_ovf;
    logic             ovf;
    logic             carry;
    logic [WIDTH-1:0] sat_val;

    always_comb begin
        sum     = {1'b0, a} + {1'b0, b};
        diff    = {1'b0, a} + {1'b0, ~b} + (WIDTH+1)'(1);
        add_ovf = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
        sub_ovf = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
        // Overflow direction always follows A's sign for both add and sub
        sat_val = a[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
        res     = '0;
        ovf     = 1'b0;
        carry   = 1'b0;
        case (fn)
            ALU_ADD: begin res = sum[WIDTH-1:0];  carry = sum[WIDTH];  ovf = add_ovf; end
            ALU_SUB: begin res = diff[WIDTH-1:0]; carry = diff[WIDTH]; ovf = sub_ovf; end
            ALU_NOT: res = ~a;
            ALU_AND: res = a & b;
            ALU_OR:  res = a | b;
            ALU_XOR: res = a ^ b;
            ALU_LT:  res = {{(WIDTH-1){1'b0}}, diff[WIDTH-1] ^ sub_ovf};
            ALU_EQ:  res = {{(WIDTH-1){1'b0}}, a == b};
            default: res = '0;
        endcase
`ifdef ALU_SAT_EN
        if (ovf) res = sat_val;
`else
        sat_val = sat_val;
`endif
        flags.zero     = (res == '0);
        flags.overflow = ovf;
        flags.carry    = carry;
    end

endmodule

// File: rtl/alu_pipe.sv
// Registered ALU with valid/ready handshake, sticky overflow and op counter.
// Saturation is selected in alu_core by the ALU_SAT_EN macro.
module alu_pipe
    import alu_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       in_fn,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_res,
    output logic             out_zero,
    output logic             out_overflow,
    output logic             out_carry,
    output logic             ovf_sticky,
    input  logic             ovf_clr,
    output logic [CNT_W-1:0] op_count
);

    logic [WIDTH-1:0] core_res;
    alu_flags_t       core_flags;
    alu_flags_t       flags_q;
    logic             accept;
    logic             retire;

    alu_core #(.WIDTH(WIDTH)) u_core (
        .fn    (alu_fn_e'(in_fn)),
        .a     (in_a),
        .b     (in_b),
        .res   (core_res),
        .flags (core_flags)
    );

    assign in_ready = !out_valid || out_ready;
    assign accept   = in_valid && in_ready;
    assign retire   = out_valid && out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_res   <= '0;
            flags_q   <= '0;
        end else if (accept) begin
            out_valid <= 1'b1;
            out_res   <= core_res;
            flags_q   <= core_flags;
        end else if (retire) begin
            out_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_sticky <= 1'b0;
            op_count   <= '0;
        end else begin
            // Set takes priority over a simultaneous clear
            if (retire && flags_q.overflow) ovf_sticky <= 1'b1;
            else if (ovf_clr)               ovf_sticky <= 1'b0;
            if (accept) op_count <= op_count + 1'b1;
        end
    end

    assign out_zero     = flags_q.zero;
    assign out_overflow = flags_q.overflow;
    assign out_carry    = flags_q.carry;

endmodule
